sbus_axi_bridge: RTL and testbench
==================================

// Module: sbus_axi_bridge
// PURPOSE
//  Converts one physical-side sbus (output of the address-translation stage) into AXI4
//  single-beat read/write transactions toward the SoC interconnect.
//  Used for the uncached data path and, until caches exist, for instruction fetch.
//  Holds the pipeline via sbus.stall until the AXI transaction completes.
//  Honours sbus.pause so a completed access is never re-issued while the pipeline is frozen.
// PARAMETERS
//  AXI_ID    0   value driven on arid/awid (4 bits)
// PORTS
//  clk       in   1    system clock
//  rst_n     in   1    asynchronous active-low reset
//  bus       sbus.slave  -  en, we, size[1:0], addr[31:0], data_w[31:0], pause in; data_r[31:0], stall out
//  arid      out  4    = AXI_ID
//  araddr    out  32   read address
//  arlen     out  8    constant 0
//  arsize    out  3    from bus.size
//  arvalid   out  1    read address valid
//  arready   in   1    read address ready
//  rdata     in   32   read data
//  rvalid    in   1    read data valid (rlast and rresp are ignored)
//  rready    out  1    read data ready
//  awid      out  4    = AXI_ID
//  awaddr    out  32   write address
//  awlen     out  8    constant 0
//  awsize    out  3    from bus.size
//  awvalid   out  1    write address valid
//  awready   in   1    write address ready
//  wdata     out  32   = latched bus.data_w (already lane-aligned by the core)
//  wstrb     out  4    byte strobes
//  wlast     out  1    constant 1
//  wvalid    out  1    write data valid
//  wready    in   1    write data ready
//  bvalid    in   1    write response valid (bresp ignored)
//  bready    out  1    write response ready
// BEHAVIOUR
//  Reset: state=IDLE; all valid/ready outputs 0; data_r=0; latched request regs=0.
//  FSM states:
//   IDLE: bus.en=1 -> latch addr, size, we, data_w; go to RA (we=0) or WA (we=1).
//   RA: arvalid=1 until arready, then R.
//   R: rready=1; on rvalid, register data_r <= rdata, then DONE.
//   WA: awvalid and wvalid both raised. Each drops on its own handshake (aw_ok/w_ok flags).
//       When both handshakes are done (possibly in the same cycle) -> B.
//   B: bready=1; on bvalid -> DONE.
//   DONE: stall=0; data_r held. pause=1 -> stay in DONE; pause=0 -> IDLE (new en accepted the next cycle).
//  stall = bus.en & (state != DONE), combinational.
//   Minimum read latency: 3 cycles of stall with arready=rvalid=1 (IDLE, RA, R).
//  size map: 00 -> arsize/awsize 3'd0, 01 -> 3'd1, 10 -> 3'd2; 11 is illegal and is treated as 10.
//  wstrb, with a = addr[1:0]:
//   byte: 4'b0001 << a
//   half: a[1] ? 4'b1100 : 4'b0011
//   word: 4'b1111
//  Addresses are passed unmodified; data_r is the raw 32-bit beat, with no lane shifting.
//  AXI handshakes: valid stays asserted with stable payload until ready.
//  bus.en dropping mid-transaction does not abort; the transaction completes into DONE and leaves DONE when pause=0.
//  rresp/bresp errors are not reported; data is delivered as received.
//  Asynchronous reset mid-transaction: return to IDLE, drop all valids immediately.
// STRUCTURE
//  includes package additions:
//   bridge_state_t enum {IDLE, RA, R, WA, B, DONE}
//   AXI size constants
//   function size_to_strb(size, addr_lo)
//  No sub-module; one FSM always_ff plus combinational output decode.
// TESTING
//  1. Word read, addr 0x1FC0_0000, arready/rvalid immediate, rdata 0xDEADBEEF:
//     stall high for 3 cycles, then data_r=0xDEADBEEF; arsize=2.
//  2. Byte write, addr 0x0000_0013, data_w 0xAB000000:
//     awsize=0, wstrb=4'b1000, wlast=1; stall drops 1 cycle after bvalid.
//  3. Write with wready 4 cycles before awready:
//     wvalid drops after its handshake, awvalid held; B entered only after both handshakes.
//  4. Read completes while pause=1 for 5 cycles: stays in DONE, no second arvalid, data_r stable;
//     after pause falls, a new en issues a new AR.
//  5. rst_n pulsed low while in R: arvalid/rready/stall all 0 asynchronously; next en restarts from RA.
//  6. Half read at addr 0x..2 with arready delayed 3 cycles:
//     araddr and arsize=1 stable while arvalid is high.

Source files
------------

// File: rtl/sbus_axi_bridge_pkg.sv
// Shared types and helpers for the sbus-to-AXI4 single-beat bridge.
package sbus_axi_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 8;

  localparam logic [2:0] AXI_SIZE_BYTE = 3'd0;
  localparam logic [2:0] AXI_SIZE_HALF = 3'd1;
  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

  typedef enum logic [2:0] {IDLE, RA, R, WA, B, DONE} bridge_state_t;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } bridge_req_t;

  // sbus size code to AXI size; the illegal code 11 behaves as a word
  function automatic logic [2:0] size_to_axi(input logic [1:0] size);
    logic [2:0] axsize;
    case (size)
      2'b00:   axsize = AXI_SIZE_BYTE;
      2'b01:   axsize = AXI_SIZE_HALF;
      default: axsize = AXI_SIZE_WORD;
    endcase
    return axsize;
  endfunction

  function automatic logic [STRB_W-1:0] size_to_strb(input logic [1:0] size,
                                                      input logic [1:0] addr_lo);
    logic [STRB_W-1:0] strb;
    case (size)
      2'b00:   strb = STRB_W'(4'b0001 << addr_lo);
      2'b01:   strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sbus.sv
// Physical-side pipeline bus between the address-translation stage and a memory port.
interface sbus;
  logic        en;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] data_w;
  logic        pause;
  logic [31:0] data_r;
  logic        stall;

  modport master (output en, we, size, addr, data_w, pause, input data_r, stall);
  modport slave  (input en, we, size, addr, data_w, pause, output data_r, stall);
endinterface

// File: rtl/sbus_axi_bridge.sv
// Bridges one sbus request at a time onto AXI4 single-beat reads/writes,
// stalling the pipeline until the response arrives.
module sbus_axi_bridge
  import sbus_axi_bridge_pkg::*;
#(
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  sbus.slave                bus,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [LEN_W-1:0]  awlen,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  bridge_state_t     state, state_nxt;
  bridge_req_t       req_q;
  logic              aw_ok, w_ok;
  logic [DATA_W-1:0] data_r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request latch, per-channel write handshake flags and read data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= '0;
      aw_ok    <= 1'b0;
      w_ok     <= 1'b0;
      data_r_q <= '0;
    end else begin
      if (state == IDLE && bus.en) begin
        req_q <= '{we: bus.we, size: bus.size, addr: bus.addr, data: bus.data_w};
        aw_ok <= 1'b0;
        w_ok  <= 1'b0;
      end
      if (awvalid && awready) aw_ok <= 1'b1;
      if (wvalid && wready)   w_ok  <= 1'b1;
      if (state == R && rvalid) data_r_q <= rdata;
    end
  end

  // Next state and channel valid/ready decode
  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state)
      IDLE: if (bus.en) state_nxt = bus.we ? WA : RA;
      RA: begin
        arvalid = 1'b1;
        if (arready) state_nxt = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid) state_nxt = DONE;
      end
      WA: begin
        awvalid = !aw_ok;
        wvalid  = !w_ok;
        // AW and W may complete in either order or in the same cycle
        if ((aw_ok || awready) && (w_ok || wready)) state_nxt = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = DONE;
      end
      DONE:    if (!bus.pause) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign arid   = AXI_ID;
  assign araddr = req_q.addr;
  assign arlen  = '0;
  assign arsize = size_to_axi(req_q.size);
  assign awid   = AXI_ID;
  assign awaddr = req_q.addr;
  assign awlen  = '0;
  assign awsize = size_to_axi(req_q.size);
  assign wdata  = req_q.data;
  assign wstrb  = size_to_strb(req_q.size, req_q.addr[1:0]);
  assign wlast  = 1'b1;

  assign bus.data_r = data_r_q;
  assign bus.stall  = bus.en && (state != DONE);

endmodule

// File: tb/tb_sbus_axi_bridge.sv
// Directed bench for sbus_axi_bridge: vector table plus multi-cycle corner sequences.
module tb_sbus_axi_bridge;

  logic        clk;
  logic        rst_n;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  wstrb;

  sbus bus_if ();

  sbus_axi_bridge #(.AXI_ID(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;
  int ar_d, r_d, aw_d, w_d, b_d;
  logic [31:0] rdata_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AXI slave: each ready/valid rises a programmable number of cycles after the request appears
  initial begin : ar_resp
    int cnt;
    cnt = 0; arready = 1'b0;
    forever begin
      @(negedge clk);
      if (arvalid) begin
        if (cnt >= ar_d) arready = 1'b1;
        else begin arready = 1'b0; cnt++; end
      end else begin arready = 1'b0; cnt = 0; end
    end
  end

  initial begin : r_resp
    int cnt;
    cnt = 0; rvalid = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      rdata = rdata_val;
      if (rready) begin
        if (cnt >= r_d) rvalid = 1'b1;
        else begin rvalid = 1'b0; cnt++; end
      end else begin rvalid = 1'b0; cnt = 0; end
    end
  end

  initial begin : aw_resp
    int cnt;
    cnt = 0; awready = 1'b0;
    forever begin
      @(negedge clk);
      if (awvalid) begin
        if (cnt >= aw_d) awready = 1'b1;
        else begin awready = 1'b0; cnt++; end
      end else begin awready = 1'b0; cnt = 0; end
    end
  end

  initial begin : w_resp
    int cnt;
    cnt = 0; wready = 1'b0;
    forever begin
      @(negedge clk);
      if (wvalid) begin
        if (cnt >= w_d) wready = 1'b1;
        else begin wready = 1'b0; cnt++; end
      end else begin wready = 1'b0; cnt = 0; end
    end
  end

  initial begin : b_resp
    int cnt;
    cnt = 0; bvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (bready) begin
        if (cnt >= b_d) bvalid = 1'b1;
        else begin bvalid = 1'b0; cnt++; end
      end else begin bvalid = 1'b0; cnt = 0; end
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          ar_d, r_d, aw_d, w_d, b_d;
    logic [2:0]  exp_size;
    logic [3:0]  exp_strb;
    int          exp_stall;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  // One full transaction: drive request, watch payload while valid, check latency and result
  task automatic run_vec(input string tag, input vec_t v);
    int n, bad, seen, exp_seen;
    ar_d = v.ar_d; r_d = v.r_d; aw_d = v.aw_d; w_d = v.w_d; b_d = v.b_d;
    rdata_val = v.rdat;
    bus_if.en = 1'b1; bus_if.we = v.we; bus_if.size = v.size;
    bus_if.addr = v.addr; bus_if.data_w = v.wdat;
    #1;
    n = 0; bad = 0; seen = 0;
    while (bus_if.stall && n < 60) begin
      n++;
      if (arvalid) begin
        seen++;
        if (araddr !== v.addr || arsize !== v.exp_size || arlen !== 8'd0 || arid !== 4'd0) bad++;
      end
      if (awvalid) begin
        seen++;
        if (awaddr !== v.addr || awsize !== v.exp_size || awlen !== 8'd0 || awid !== 4'd0) bad++;
      end
      if (wvalid) begin
        seen++;
        if (wdata !== v.wdat || wstrb !== v.exp_strb || wlast !== 1'b1) bad++;
      end
      tick();
    end
    exp_seen = v.we ? (2 + v.aw_d + v.w_d) : (1 + v.ar_d);
    check({tag, " stall_cycles"}, 32'(n), 32'(v.exp_stall));
    check({tag, " payload_errors"}, 32'(bad), 32'd0);
    check({tag, " valid_cycles"}, 32'(seen), 32'(exp_seen));
    if (!v.we) check({tag, " data_r"}, bus_if.data_r, v.rdat);
    bus_if.en = 1'b0;
    tick();
  endtask

  initial begin
    int n, wdrop, bfirst, ar_seen, stall_seen, dr_changed;
    logic [31:0] dr_hold;
    vec_t v;
    n_checks = 0; n_pass = 0;
    ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0; rdata_val = '0;

    //          we    size   addr          wdat          rdat          ar r aw w b  size  strb     stall
    vecs[0] = '{1'b0, 2'b10, 32'h1FC0_0000, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 0, 3'd2, 4'b1111, 3};
    vecs[1] = '{1'b1, 2'b00, 32'h0000_0013, 32'hAB00_0000, 32'h0,       0, 0, 0, 0, 0, 3'd0, 4'b1000, 3};
    vecs[2] = '{1'b1, 2'b00, 32'h0000_0010, 32'h0000_00CD, 32'h0,       0, 0, 0, 0, 0, 3'd0, 4'b0001, 3};
    vecs[3] = '{1'b1, 2'b00, 32'h0000_0011, 32'h0000_EF00, 32'h0,       0, 0, 0, 0, 2, 3'd0, 4'b0010, 5};
    vecs[4] = '{1'b1, 2'b01, 32'h0000_0022, 32'h1234_0000, 32'h0,       0, 0, 0, 0, 0, 3'd1, 4'b1100, 3};
    vecs[5] = '{1'b1, 2'b01, 32'h0000_0020, 32'h0000_5678, 32'h0,       0, 0, 1, 2, 0, 3'd1, 4'b0011, 5};
    vecs[6] = '{1'b1, 2'b10, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,       0, 0, 0, 0, 0, 3'd2, 4'b1111, 3};
    vecs[7] = '{1'b1, 2'b11, 32'h0000_0101, 32'h0102_0304, 32'h0,       0, 0, 0, 0, 0, 3'd2, 4'b1111, 3};
    vecs[8] = '{1'b0, 2'b01, 32'h8000_1002, 32'h0,        32'h12345678, 3, 0, 0, 0, 0, 3'd1, 4'b1111, 6};
    vecs[9] = '{1'b0, 2'b00, 32'h0000_0003, 32'h0,        32'hA5000000, 0, 2, 0, 0, 0, 3'd0, 4'b1111, 5};

    bus_if.en = 1'b0; bus_if.we = 1'b0; bus_if.size = 2'b00;
    bus_if.addr = '0; bus_if.data_w = '0; bus_if.pause = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    check("reset arvalid", 32'(arvalid), 32'd0);
    check("reset awvalid", 32'(awvalid), 32'd0);
    check("reset wvalid", 32'(wvalid), 32'd0);
    check("reset rready", 32'(rready), 32'd0);
    check("reset bready", 32'(bready), 32'd0);
    check("reset data_r", bus_if.data_r, 32'h0);
    check("reset stall", 32'(bus_if.stall), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // W accepted four cycles before AW: wvalid drops alone, B waits for both
    aw_d = 4; w_d = 0; b_d = 0;
    bus_if.en = 1'b1; bus_if.we = 1'b1; bus_if.size = 2'b10;
    bus_if.addr = 32'h0000_0040; bus_if.data_w = 32'h5A5A_5A5A;
    #1;
    n = 0; wdrop = 0; bfirst = 0;
    while (bus_if.stall && n < 60) begin
      n++;
      if (awvalid && !wvalid) wdrop++;
      if (bready && bfirst == 0) bfirst = n;
      tick();
    end
    check("split stall_cycles", 32'(n), 32'd7);
    check("split wvalid_dropped_cycles", 32'(wdrop), 32'd4);
    check("split first_bready_cycle", 32'(bfirst), 32'd7);
    bus_if.en = 1'b0;
    aw_d = 0;
    tick();

    // Read completes under pause: no re-issue while frozen, then a fresh request proceeds
    bus_if.pause = 1'b1;
    v = '{1'b0, 2'b10, 32'h0000_2000, 32'h0, 32'h11223344, 0, 0, 0, 0, 0, 3'd2, 4'b1111, 3};
    run_vec("pause_rd", v);
    dr_hold = bus_if.data_r;
    bus_if.en = 1'b1; bus_if.we = 1'b0; bus_if.addr = 32'h0000_3000;
    ar_seen = 0; stall_seen = 0; dr_changed = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (arvalid) ar_seen++;
      if (bus_if.stall) stall_seen++;
      if (bus_if.data_r !== dr_hold) dr_changed++;
      tick();
    end
    check("pause arvalid_cycles", 32'(ar_seen), 32'd0);
    check("pause stall_cycles", 32'(stall_seen), 32'd0);
    check("pause data_r_changes", 32'(dr_changed), 32'd0);
    bus_if.en = 1'b0; bus_if.pause = 1'b0;
    tick();
    v = '{1'b0, 2'b10, 32'h0000_3000, 32'h0, 32'h55667788, 0, 0, 0, 0, 0, 3'd2, 4'b1111, 3};
    run_vec("post_pause_rd", v);

    // Reset asserted while waiting in R
    r_d = 10; rdata_val = 32'hFFFF_0000;
    bus_if.en = 1'b1; bus_if.we = 1'b0; bus_if.size = 2'b10; bus_if.addr = 32'h0000_4000;
    n = 0;
    while (!rready && n < 20) begin n++; tick(); end
    check("rst_mid reached_r", 32'(rready), 32'd1);
    rst_n = 1'b0; bus_if.en = 1'b0;
    #1;
    check("rst_mid arvalid", 32'(arvalid), 32'd0);
    check("rst_mid rready", 32'(rready), 32'd0);
    check("rst_mid stall", 32'(bus_if.stall), 32'd0);
    check("rst_mid data_r", bus_if.data_r, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    v = '{1'b0, 2'b10, 32'h0000_4000, 32'h0, 32'h0BADF00D, 0, 0, 0, 0, 0, 3'd2, 4'b1111, 3};
    run_vec("rst_restart_rd", v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
